// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared constants, state encoding and helpers for the line arbiter
//
// Purpose : caller count, idle character, FSM state encoding and small
//           arithmetic helpers shared by line_arbiter and rr_arbiter4.
// Ports   : none (package).

package line_pkg;

  localparam int          N_CALLERS  = 4;
  localparam logic [7:0]  CHAR_SPACE = 8'h20;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_ACTIVE    = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Add a small increment to an 8-bit counter, pinning at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'b000000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin selector
//
// Purpose : picks the first set request bit, scanning upward from ptr and
//           wrapping modulo 4.
// Ports   : req [3:0] in  - request vector
//           ptr [1:0] in  - first index to consider
//           gnt [3:0] out - one-hot winner (zero when none)
//           idx [1:0] out - winner index (zero when none)
//           any       out - at least one request present

module rr_arbiter4
  import line_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  always_comb begin
    gnt  = 4'b0000;
    idx  = 2'd0;
    any  = 1'b0;
    cand = 2'd0;
    for (int i = 0; i < N_CALLERS; i++) begin
      // 2-bit addition wraps naturally, giving the circular scan order.
      cand = ptr + 2'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
        gnt = 4'b0001 << cand;
      end
    end
  end

endmodule

// File: rtl/line_arbiter.sv
// rtl/line_arbiter.sv - grants a shared telephone line to one of four callers
//
// Purpose : round-robin ownership of one line, call setup/teardown pulses,
//           character forwarding from the owner, drop and call statistics.
// Ports   : clk, rst (async, active-high)
//           req[3:0], rel[3:0], char_valid[3:0], char_data[31:0] - callers
//           line_idle                                           - line status
//           gnt[3:0], owner[1:0]                                - ownership
//           line_start, line_end, line_send, line_char[7:0]     - to the line
//           calls_served[15:0], drop_cnt[7:0], start_fail       - status
// All outputs come straight from flops.

module line_arbiter
  import line_pkg::*;
#(
  parameter int MAX_HOLD = 200,
  parameter int START_TO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  rel,
  input  logic [3:0]  char_valid,
  input  logic [31:0] char_data,
  input  logic        line_idle,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        line_start,
  output logic        line_end,
  output logic        line_send,
  output logic [7:0]  line_char,
  output logic [15:0] calls_served,
  output logic [7:0]  drop_cnt,
  output logic        start_fail
);

  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int WAIT_W = (START_TO > 2) ? $clog2(START_TO) : 1;

  logic [2:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        owner_q, owner_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              line_start_q, line_start_d;
  logic              line_end_q, line_end_d;
  logic              line_send_q, line_send_d;
  logic [7:0]        line_char_q, line_char_d;
  logic [15:0]       calls_q, calls_d;
  logic [7:0]        drop_q, drop_d;
  logic              start_fail_q, start_fail_d;

  logic [3:0] rr_gnt;
  logic [1:0] rr_idx;
  logic       rr_any;

  logic [3:0] own_mask;
  logic [3:0] dropped;
  logic [7:0] owner_char;

  rr_arbiter4 u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  always_comb begin
    own_mask   = 4'b0001 << owner_q;
    owner_char = char_data[{owner_q, 3'b000} +: 8];
    // Only the owner's strobe in ACTIVE is consumed; everything else is lost.
    dropped    = char_valid & ~((state_q == ST_ACTIVE) ? own_mask : 4'b0000);
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    gnt_d        = gnt_q;
    hold_d       = hold_q;
    wait_d       = wait_q;
    line_start_d = 1'b0;
    line_end_d   = 1'b0;
    line_send_d  = 1'b0;
    line_char_d  = line_char_q;
    calls_d      = calls_q;
    drop_d       = sat_add8(drop_q, popcount4(dropped));
    start_fail_d = start_fail_q;

    case (state_q)
      ST_IDLE: begin
        if (line_idle && rr_any) begin
          owner_d = rr_idx;
          gnt_d   = rr_gnt;
          ptr_d   = rr_idx + 2'd1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        line_start_d = 1'b1;
        wait_d       = '0;
        state_d      = ST_WAIT_BUSY;
      end

      ST_WAIT_BUSY: begin
        if (!line_idle) begin
          hold_d  = '0;
          state_d = ST_ACTIVE;
        end else if (wait_q == WAIT_W'(START_TO - 1)) begin
          start_fail_d = 1'b1;
          gnt_d        = 4'b0000;
          owner_d      = 2'd0;
          state_d      = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_ACTIVE: begin
        hold_d = hold_q + 1'b1;
        if (char_valid[owner_q]) begin
          line_send_d = 1'b1;
          line_char_d = owner_char;
        end
        // The line going idle means the far end already hung up, so no
        // line_end is sent and the call is closed immediately.
        if (line_idle) begin
          calls_d = calls_q + 16'd1;
          gnt_d   = 4'b0000;
          owner_d = 2'd0;
          state_d = ST_IDLE;
        end else if (rel[owner_q] || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
          line_end_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (line_idle) begin
          calls_d = calls_q + 16'd1;
          gnt_d   = 4'b0000;
          owner_d = 2'd0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        gnt_d   = 4'b0000;
        owner_d = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 2'd0;
      owner_q      <= 2'd0;
      gnt_q        <= 4'b0000;
      hold_q       <= '0;
      wait_q       <= '0;
      line_start_q <= 1'b0;
      line_end_q   <= 1'b0;
      line_send_q  <= 1'b0;
      line_char_q  <= CHAR_SPACE;
      calls_q      <= 16'd0;
      drop_q       <= 8'd0;
      start_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      hold_q       <= hold_d;
      wait_q       <= wait_d;
      line_start_q <= line_start_d;
      line_end_q   <= line_end_d;
      line_send_q  <= line_send_d;
      line_char_q  <= line_char_d;
      calls_q      <= calls_d;
      drop_q       <= drop_d;
      start_fail_q <= start_fail_d;
    end
  end

  assign gnt          = gnt_q;
  assign owner        = owner_q;
  assign line_start   = line_start_q;
  assign line_end     = line_end_q;
  assign line_send    = line_send_q;
  assign line_char    = line_char_q;
  assign calls_served = calls_q;
  assign drop_cnt     = drop_q;
  assign start_fail   = start_fail_q;

endmodule
